// File: rtl/sum_checker_pkg.sv
// Shared types and defaults for the sum checker.
// State encoding is fixed at two bits.
package sum_checker_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMPARE = 2'd2,
    RESULT  = 2'd3
  } state_t;

  localparam int unsigned DEF_NUM_ENTRIES    = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 50000;

endpackage

// File: rtl/sum_checker_timeout_counter.sv
// Idle-cycle counter for the sum checker.
// tc flags the last allowed idle cycle.
module timeout_counter #(
  parameter int unsigned LIMIT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign tc = (cnt_q == 16'(LIMIT - 1));

endmodule

// File: rtl/sum_checker.sv
// Collects NUM_ENTRIES operands, sums them and
// compares against a captured target.
module sum_checker
  import sum_checker_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES    = DEF_NUM_ENTRIES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] target,
  input  logic [3:0] num_in,
  input  logic       num_valid,
  output logic       busy,
  output logic [2:0] entry_cnt,
  output logic [7:0] sum,
  output logic       done,
  output logic       win,
  output logic       lose
);

  localparam logic [3:0] LAST = 4'(NUM_ENTRIES - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] target_q;
  logic       tc;
  logic       start_ok;
  logic       accept;
  logic       last;
  logic       tmo;
  logic       tmr_clr;
  logic       tmr_en;

  assign start_ok = (state_q == IDLE) && start;
  assign accept   = (state_q == COLLECT) && num_valid;
  assign last     = accept && ({1'b0, entry_cnt} == LAST);
  // A valid operand always wins over the terminal count
  assign tmo      = (state_q == COLLECT) && !num_valid && tc;
  assign tmr_clr  = start_ok || accept;
  assign tmr_en   = (state_q == COLLECT) && !num_valid && !tc;

  timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clr),
    .enable (tmr_en),
    .tc     (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = COLLECT;
      COLLECT: begin
        if (last)     state_d = COMPARE;
        else if (tmo) state_d = RESULT;
      end
      COMPARE: state_d = RESULT;
      RESULT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      entry_cnt <= '0;
      sum       <= '0;
      win       <= 1'b0;
      lose      <= 1'b0;
      target_q  <= '0;
    end else begin
      busy <= (state_d != IDLE);
      done <= (state_d == RESULT);
      if (start_ok) begin
        entry_cnt <= '0;
        sum       <= '0;
        win       <= 1'b0;
        lose      <= 1'b0;
        target_q  <= target;
      end
      if (accept) begin
        sum       <= sum + {4'b0, num_in};
        entry_cnt <= entry_cnt + 3'd1;
      end
      if (tmo) begin
        win  <= 1'b0;
        lose <= 1'b1;
      end
      if (state_q == COMPARE) begin
        win  <= (sum == target_q);
        lose <= (sum != target_q);
      end
    end
  end

endmodule

// File: tb/tb_sum_checker.sv
// Randomized self-checking bench for sum_checker.
// Rounds are scored with plain arithmetic.
module tb_sum_checker;

  localparam int NE = 4;
  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] target;
  logic [3:0] num_in;
  logic       num_valid;
  logic       busy;
  logic [2:0] entry_cnt;
  logic [7:0] sum;
  logic       done;
  logic       win;
  logic       lose;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sum_checker #(
    .NUM_ENTRIES    (NE),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .target    (target),
    .num_in    (num_in),
    .num_valid (num_valid),
    .busy      (busy),
    .entry_cnt (entry_cnt),
    .sum       (sum),
    .done      (done),
    .win       (win),
    .lose      (lose)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag,
                            input logic eb, ed, ew, el,
                            input int ec, es);
    check({tag, ".busy"}, 32'(busy), 32'(eb));
    check({tag, ".done"}, 32'(done), 32'(ed));
    check({tag, ".win"}, 32'(win), 32'(ew));
    check({tag, ".lose"}, 32'(lose), 32'(el));
    check({tag, ".cnt"}, 32'(entry_cnt), 32'(ec));
    check({tag, ".sum"}, 32'(sum), 32'(es));
    check({tag, ".excl"}, 32'(win & lose), 32'd0);
  endtask

  // gaps[i] = idle cycles before operand i; TO idle cycles lose the round
  task automatic play_round(input logic [7:0] tgt,
                            input int ops[NE],
                            input int gaps[NE],
                            input bit noise);
    int  s;
    int  n;
    bit  lost;
    logic w;
    s    = 0;
    n    = 0;
    lost = 1'b0;
    start  = 1'b1;
    target = tgt;
    tick();
    start  = 1'b0;
    target = 8'($urandom);
    check_outs("start", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < NE; i++) begin
      for (int j = 0; j < gaps[i]; j++) begin
        if (noise && $urandom_range(0, 3) == 0) begin
          start  = 1'b1;
          target = 8'd99;
        end
        tick();
        start = 1'b0;
        if (j + 1 == TO) begin
          lost = 1'b1;
          break;
        end
        check_outs("idle", 1, 0, 0, 0, n, s);
      end
      if (lost) break;
      num_valid = 1'b1;
      num_in    = 4'(ops[i]);
      tick();
      num_valid = 1'b0;
      num_in    = 4'($urandom);
      s += ops[i];
      n++;
      check_outs("accept", 1, 0, 0, 0, n, s);
    end
    if (lost) begin
      check_outs("timeout", 1, 1, 0, 1, n, s);
      tick();
      w = 1'b0;
      check_outs("tmo_end", 0, 0, 0, 1, n, s);
    end else begin
      tick();
      w = (s[7:0] == tgt);
      check_outs("result", 1, 1, w, !w, n, s);
      tick();
      check_outs("res_end", 0, 0, w, !w, n, s);
    end
    num_valid = 1'b1;
    num_in    = 4'($urandom_range(1, 15));
    tick();
    num_valid = 1'b0;
    check_outs("idle_nv", 0, 0, w, lost | !w, n, s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ops[NE];
    int gaps[NE];
    int tot;
    int r;
    rst       = 1'b0;
    start     = 1'b0;
    target    = '0;
    num_in    = '0;
    num_valid = 1'b0;
    tick();
    tick();
    check_outs("por", 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    check_outs("post_rst", 0, 0, 0, 0, 0, 0);

    ops  = '{3, 5, 2, 6};
    gaps = '{2, 2, 2, 2};
    play_round(8'd16, ops, gaps, 1'b1);
    play_round(8'd15, ops, gaps, 1'b1);

    ops  = '{7, 1, 1, 1};
    gaps = '{0, TO + 3, 0, 0};
    play_round(8'd10, ops, gaps, 1'b0);

    ops  = '{1, 2, 3, 4};
    gaps = '{TO - 1, TO - 1, 0, TO - 1};
    play_round(8'd10, ops, gaps, 1'b1);

    start  = 1'b1;
    target = 8'd16;
    tick();
    start     = 1'b0;
    num_valid = 1'b1;
    num_in    = 4'd5;
    tick();
    num_in    = 4'd9;
    tick();
    num_valid = 1'b0;
    check_outs("pre_rst", 1, 0, 0, 0, 2, 14);
    rst = 1'b0;
    #1;
    check_outs("async_rst", 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    check_outs("held_rst", 0, 0, 0, 0, 0, 0);
    ops  = '{4, 4, 4, 4};
    gaps = '{1, 0, 2, 0};
    play_round(8'd16, ops, gaps, 1'b0);

    for (int k = 0; k < 30; k++) begin
      tot = 0;
      for (int i = 0; i < NE; i++) begin
        ops[i] = $urandom_range(0, 15);
        tot += ops[i];
        r = $urandom_range(0, 9);
        if (r < 6)      gaps[i] = $urandom_range(0, 3);
        else if (r < 8) gaps[i] = TO - 1;
        else            gaps[i] = TO + $urandom_range(0, 2);
      end
      if ($urandom_range(0, 1) == 1)
        play_round(8'(tot), ops, gaps, 1'b1);
      else
        play_round(8'($urandom_range(0, 63)), ops, gaps, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_checker.md
SUM_CHECKER -- requirements
Module: sum_checker

Interface
REQ-001 Parameter NUM_ENTRIES, default 4, is the number of operands per round; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, is the idle cycles allowed between operands before the round is lost; legal range 2..65535.
REQ-003 Port clk  input  1  is the single system clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is the reset: asynchronous, active-low.
REQ-005 Port start  input  1  is a one-cycle pulse that begins a round.
REQ-006 Port target  input  8  is the round target sum, sampled on an accepted start.
REQ-007 Port num_in  input  4  is the operand from the upstream load register.
REQ-008 Port num_valid  input  1  is a one-cycle pulse marking num_in valid.
REQ-009 Port busy  output  1  is high while a round is in progress (state not IDLE).
REQ-010 Port entry_cnt  output  3  is the number of operands accepted this round.
REQ-011 Port sum  output  8  is the running unsigned sum of accepted operands.
REQ-012 Port done  output  1  is a one-cycle pulse marking the round result.
REQ-013 Port win  output  1  is high when the round sum equals the target; held until the next accepted start.
REQ-014 Port lose  output  1  is high when the round ends by mismatch or timeout; held until the next accepted start.

Function
REQ-015 FSM states SHALL be IDLE, COLLECT, COMPARE and RESULT, all registered.
REQ-016 IDLE with start=1: next edge -> COLLECT; sum=0, entry_cnt=0, win=0, lose=0, timeout counter=0, target captured into target_q.
REQ-017 COLLECT with num_valid=1: next edge adds zero-extended num_in to sum, increments entry_cnt and clears the timeout counter.
REQ-018 COLLECT, operand that makes entry_cnt equal NUM_ENTRIES is accepted: next state is COMPARE; latency from that num_valid to done is 2 edges.
REQ-019 COLLECT with num_valid=0: timeout counter increments; on reaching TIMEOUT_CYCLES-1 -> RESULT with lose=1, win=0.
REQ-020 num_valid and timeout terminal count in the same cycle: the operand is accepted and the timeout does not fire.
REQ-021 COMPARE lasts one cycle: win=(sum==target_q), lose=~win, next state RESULT.
REQ-022 RESULT lasts one cycle with done=1, then IDLE; done is 0 in every other state.
REQ-023 start outside IDLE SHALL be ignored; target changes after capture SHALL have no effect.
REQ-024 num_valid outside COLLECT SHALL be ignored; sum and entry_cnt are unchanged.
REQ-025 Sum width is 8 bits; the maximum of 8*15=120 cannot overflow; no saturation logic.
REQ-026 win and lose SHALL never both be 1.

Reset
REQ-027 rst low at any time, including mid-round, SHALL immediately force IDLE, busy=0, entry_cnt=0, sum=0, done=0, win=0, lose=0, timeout counter=0 and target_q=0.
REQ-028 After rst is released, the first round SHALL begin on the first accepted start.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (2-bit: IDLE=0, COLLECT=1, COMPARE=2, RESULT=3) and the default NUM_ENTRIES and TIMEOUT_CYCLES constants.
REQ-030 The timeout counter SHALL be one sub-module, timeout_counter, with clear, enable and a terminal-count output.
REQ-031 Every output SHALL be driven directly from a flop.

Verification
REQ-032 target=16; start; operands 3,5,2,6 spaced 3 cycles apart -> sum=16, entry_cnt=4, done pulse 2 edges after last valid, win=1, lose=0.
REQ-033 target=15; same operands -> sum=16, done pulse, win=0, lose=1.
REQ-034 TIMEOUT_CYCLES=10; start; one operand 7, then none -> RESULT at timeout terminal count, lose=1, sum=7, entry_cnt=1.
REQ-035 Round with 2 operands accepted; rst low for 1 cycle -> all outputs 0 and busy=0 asynchronously; next round with 4,4,4,4 against target=16 -> win=1.
REQ-036 During COLLECT: start pulse with target=99 -> ignored, result compares against the original target. In IDLE: num_valid pulse -> sum and entry_cnt unchanged.
REQ-037 num_valid coincident with timeout terminal count -> operand accepted, no timeout, round continues.
